otter_cu_fsm: RTL and testbench
===============================

// Module: otter_cu_fsm
// PURPOSE
//  Multi-cycle control FSM for the Otter RV32I core, directly upstream of the PC source mux.
//  Sequences FETCH/EXEC/WRITEBACK/INTERRUPT and decodes opcode, func3 and branch flags.
//  Produces PC_SEL (mux select) and PC_WRITE (PC register load enable).
//  Also drives regfile/memory/CSR strobes and the trap/mret handshake to the CSR block.
// PARAMETERS
//  FETCH_WAIT  1  cycles MEM_RDEN1 is held in FETCH before EXEC (IMEM read latency, >=1)
// PORTS
//  CLK        in   1  system clock, all state on rising edge
//  RST_N      in   1  reset, asynchronous assert, active-low; the only reset
//  OPCODE     in   7  IR[6:0]
//  FUNC3      in   3  IR[14:12]
//  FUNC12     in   12 IR[31:20], used only to identify mret (12'h302)
//  BR_EQ      in   1  rs1 == rs2
//  BR_LT      in   1  rs1 < rs2, signed
//  BR_LTU     in   1  rs1 < rs2, unsigned
//  INTR       in   1  interrupt pending, already masked by mstatus.MIE in the CSR block
//  PC_SEL     out  3  000 +4, 001 JALR, 010 BRANCH, 011 JAL, 100 MTVEC, 101 MEPC
//  PC_WRITE   out  1  load PC from mux output this edge
//  REG_WRITE  out  1  regfile write enable
//  MEM_RDEN1  out  1  instruction memory read enable
//  MEM_RDEN2  out  1  data memory read enable
//  MEM_WE2    out  1  data memory write enable
//  CSR_WE     out  1  CSR write enable
//  INT_TAKEN  out  1  one-cycle trap pulse: CSR block saves MEPC and clears MIE
//  MRET_EXEC  out  1  one-cycle mret pulse: CSR block restores MIE
// BEHAVIOUR
//  - RST_N=0: state=FETCH, wait counter=0, all outputs 0 (also gated 0 while RST_N low).
//  - Outputs are combinational from registered state plus inputs. PC_SEL=000 whenever PC_WRITE=0.
//  - FETCH: MEM_RDEN1=1. Counter counts 0..FETCH_WAIT-1, then goes to EXEC. Counter clears on exit.
//  - EXEC, all instructions: PC_WRITE=1.
//  - EXEC, load (0000011): MEM_RDEN2=1, PC_SEL=000. Next state is WRITEBACK.
//  - EXEC, store (0100011): MEM_WE2=1, PC_SEL=000.
//  - EXEC, OP/OP-IMM/LUI/AUIPC: REG_WRITE=1, PC_SEL=000.
//  - EXEC, JAL: REG_WRITE=1, PC_SEL=011. JALR: REG_WRITE=1, PC_SEL=001.
//  - EXEC, branch (1100011): PC_SEL=010 if taken, else 000; REG_WRITE=0.
//    Taken condition by func3: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU.
//    func3 010/011 are never taken.
//  - EXEC, SYSTEM (1110011):
//    func3=000 and FUNC12=302: MRET_EXEC=1, PC_SEL=101.
//    func3 != 000: CSR_WE=1, REG_WRITE=1, PC_SEL=000.
//    Other func3=000 encodings behave as NOP.
//  - EXEC, unknown opcode: NOP. PC_WRITE=1, PC_SEL=000, no other strobes.
//  - WRITEBACK: REG_WRITE=1, PC_WRITE=0.
//  - Interrupt check happens at instruction end (exit of EXEC for non-load, exit of WRITEBACK):
//    INTR=1 -> next state INTERRUPT; else FETCH.
//  - INTR is ignored in FETCH and in load EXEC. It is not latched; the CSR block holds it.
//  - Interrupt check on mret EXEC: INTR=1 (source still pending) -> INTERRUPT anyway.
//  - INTERRUPT: PC_WRITE=1, PC_SEL=100, INT_TAKEN=1, all other strobes 0. Next state FETCH.
//    No nested check: INTR in INTERRUPT is ignored.
//  - Latency per instruction: FETCH_WAIT+1 cycles; loads +1; a taken interrupt +1.
//  - Reset asserted mid-instruction aborts immediately, with no partial strobes after assertion.
//    First FETCH starts on the first CLK edge after RST_N rises.
// STRUCTURE
//  - otter_pkg holds:
//    pc_sel_t enum (PC_PLUS4=0, PC_JALR=1, PC_BRANCH=2, PC_JAL=3, PC_MTVEC=4, PC_MEPC=5);
//    cu_state_t enum (ST_FETCH, ST_EXEC, ST_WB, ST_INTR);
//    opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYS, ...);
//    FUNC12_MRET constant.
//  - Sub-module otter_branch_cond: FUNC3, BR_EQ, BR_LT, BR_LTU -> taken. Combinational, reused by the decoder.
// TESTING
//  1. RST_N low 3 cycles then high.
//     -> all outputs 0 during reset; MEM_RDEN1=1 on cycle 1 after release; EXEC on cycle 2 (FETCH_WAIT=1).
//  2. ADDI (0010011).
//     -> EXEC: REG_WRITE=1, PC_WRITE=1, PC_SEL=000; back to FETCH.
//     LW (0000011).
//     -> EXEC: MEM_RDEN2=1, PC_WRITE=1, REG_WRITE=0; WB: REG_WRITE=1, PC_WRITE=0.
//  3. BLT, func3=100: BR_LT=1 -> PC_SEL=010; BR_LT=0 -> PC_SEL=000.
//     BGEU, func3=111: BR_LTU=0 -> 010.
//     func3=010 with all flags set -> 000.
//  4. JAL -> PC_SEL=011, REG_WRITE=1. JALR -> PC_SEL=001.
//     mret (1110011/000/302) -> PC_SEL=101, MRET_EXEC=1 for exactly 1 cycle.
//  5. INTR=1 during ADD EXEC -> next cycle INTERRUPT: PC_SEL=100, PC_WRITE=1, INT_TAKEN=1 for one cycle; then FETCH.
//     INTR=1 during LW EXEC -> WB first, then INTERRUPT.
//  6. FETCH_WAIT=3.
//     -> MEM_RDEN1 high exactly 3 cycles per instruction.
//     Drop RST_N in cycle 2 of FETCH -> outputs 0 immediately; restart with a full 3-cycle FETCH.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types and encodings for the Otter RV32I multi-cycle control unit.
// Imported by the control FSM and its branch-condition helper.
package otter_pkg;

   typedef enum logic [2:0] {
      PC_PLUS4  = 3'd0,
      PC_JALR   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JAL    = 3'd3,
      PC_MTVEC  = 3'd4,
      PC_MEPC   = 3'd5
   } pc_sel_t;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR
   } cu_state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYS    = 7'b1110011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [11:0] FUNC12_MRET = 12'h302;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/otter_branch_cond.sv
// Branch-taken decision from func3 and the comparator flags.
// Purely combinational; unused func3 codes (010/011) never branch.
module otter_branch_cond
   import otter_pkg::*;
(
   input  logic [2:0] FUNC3,
   input  logic       BR_EQ,
   input  logic       BR_LT,
   input  logic       BR_LTU,
   output logic       TAKEN
);

   always_comb begin
      TAKEN = 1'b0;
      case (FUNC3)
         F3_BEQ:  TAKEN =  BR_EQ;
         F3_BNE:  TAKEN = !BR_EQ;
         F3_BLT:  TAKEN =  BR_LT;
         F3_BGE:  TAKEN = !BR_LT;
         F3_BLTU: TAKEN =  BR_LTU;
         F3_BGEU: TAKEN = !BR_LTU;
         default: TAKEN = 1'b0;
      endcase
   end

endmodule

// File: rtl/otter_cu_fsm.sv
// Multi-cycle control FSM for the Otter core: FETCH / EXEC / WRITEBACK / INTERRUPT.
// Outputs are decoded from the registered state plus the current instruction fields.
module otter_cu_fsm
   import otter_pkg::*;
#(
   parameter int FETCH_WAIT = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [6:0]  OPCODE,
   input  logic [2:0]  FUNC3,
   input  logic [11:0] FUNC12,
   input  logic        BR_EQ,
   input  logic        BR_LT,
   input  logic        BR_LTU,
   input  logic        INTR,
   output logic [2:0]  PC_SEL,
   output logic        PC_WRITE,
   output logic        REG_WRITE,
   output logic        MEM_RDEN1,
   output logic        MEM_RDEN2,
   output logic        MEM_WE2,
   output logic        CSR_WE,
   output logic        INT_TAKEN,
   output logic        MRET_EXEC
);

   localparam int CNT_W = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_WAIT - 1);

   cu_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   pc_sel_t pc_sel;
   logic    pc_write, reg_write, rden1, rden2, we2, csr_we, int_taken, mret;
   logic    br_taken;

   otter_branch_cond u_branch_cond (
      .FUNC3  (FUNC3),
      .BR_EQ  (BR_EQ),
      .BR_LT  (BR_LT),
      .BR_LTU (BR_LTU),
      .TAKEN  (br_taken)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_sel    = PC_PLUS4;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      rden1     = 1'b0;
      rden2     = 1'b0;
      we2       = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret      = 1'b0;

      case (state_q)
         ST_FETCH: begin
            rden1 = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_EXEC;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_EXEC: begin
            pc_write = 1'b1;
            case (OPCODE)
               OP_LOAD:  rden2 = 1'b1;
               OP_STORE: we2   = 1'b1;
               OP_OP, OP_IMM, OP_LUI, OP_AUIPC: reg_write = 1'b1;
               OP_JAL: begin
                  reg_write = 1'b1;
                  pc_sel    = PC_JAL;
               end
               OP_JALR: begin
                  reg_write = 1'b1;
                  pc_sel    = PC_JALR;
               end
               OP_BRANCH: if (br_taken) pc_sel = PC_BRANCH;
               OP_SYS: begin
                  if (FUNC3 != 3'b000) begin
                     csr_we    = 1'b1;
                     reg_write = 1'b1;
                  end else if (FUNC12 == FUNC12_MRET) begin
                     mret   = 1'b1;
                     pc_sel = PC_MEPC;
                  end
               end
               default: ;
            endcase
            // Loads finish in WRITEBACK, so their interrupt check is deferred there.
            if (OPCODE == OP_LOAD)
               state_d = ST_WB;
            else
               state_d = INTR ? ST_INTR : ST_FETCH;
         end

         ST_WB: begin
            reg_write = 1'b1;
            state_d   = INTR ? ST_INTR : ST_FETCH;
         end

         ST_INTR: begin
            pc_write  = 1'b1;
            pc_sel    = PC_MTVEC;
            int_taken = 1'b1;
            state_d   = ST_FETCH;
         end

         default: state_d = ST_FETCH;
      endcase
   end

   // The reset level also gates the outputs so nothing strobes while RST_N is low.
   assign PC_SEL    = RST_N ? pc_sel : PC_PLUS4;
   assign PC_WRITE  = RST_N & pc_write;
   assign REG_WRITE = RST_N & reg_write;
   assign MEM_RDEN1 = RST_N & rden1;
   assign MEM_RDEN2 = RST_N & rden2;
   assign MEM_WE2   = RST_N & we2;
   assign CSR_WE    = RST_N & csr_we;
   assign INT_TAKEN = RST_N & int_taken;
   assign MRET_EXEC = RST_N & mret;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: directed instruction table, random instructions
// against an instruction-level reference model, and reset corner cases at FETCH_WAIT=1 and 3.
module tb_otter_cu_fsm;

   typedef struct packed {
      logic [2:0] pc_sel;
      logic       pc_write;
      logic       reg_write;
      logic       rden1;
      logic       rden2;
      logic       we2;
      logic       csr_we;
      logic       int_taken;
      logic       mret;
   } outs_t;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [11:0] f12;
      logic        eq, lt, ltu, intr;
      outs_t       exp;
   } cyc_t;

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [11:0] f12;
      logic        eq, lt, ltu;
      logic        intr_exec, intr_wb;
      outs_t       exp_exec;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n1, rst_n3;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [11:0] func12;
   logic        br_eq, br_lt, br_ltu, intr;

   logic [2:0] pc_sel1, pc_sel3;
   logic pc_write1, reg_write1, rden1_1, rden2_1, we2_1, csr_we1, int_taken1, mret1;
   logic pc_write3, reg_write3, rden1_3, rden2_3, we2_3, csr_we3, int_taken3, mret3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   otter_cu_fsm #(.FETCH_WAIT(1)) dut (
      .CLK(clk), .RST_N(rst_n1), .OPCODE(opcode), .FUNC3(func3), .FUNC12(func12),
      .BR_EQ(br_eq), .BR_LT(br_lt), .BR_LTU(br_ltu), .INTR(intr),
      .PC_SEL(pc_sel1), .PC_WRITE(pc_write1), .REG_WRITE(reg_write1), .MEM_RDEN1(rden1_1),
      .MEM_RDEN2(rden2_1), .MEM_WE2(we2_1), .CSR_WE(csr_we1), .INT_TAKEN(int_taken1),
      .MRET_EXEC(mret1)
   );

   otter_cu_fsm #(.FETCH_WAIT(3)) dut3 (
      .CLK(clk), .RST_N(rst_n3), .OPCODE(opcode), .FUNC3(func3), .FUNC12(func12),
      .BR_EQ(br_eq), .BR_LT(br_lt), .BR_LTU(br_ltu), .INTR(intr),
      .PC_SEL(pc_sel3), .PC_WRITE(pc_write3), .REG_WRITE(reg_write3), .MEM_RDEN1(rden1_3),
      .MEM_RDEN2(rden2_3), .MEM_WE2(we2_3), .CSR_WE(csr_we3), .INT_TAKEN(int_taken3),
      .MRET_EXEC(mret3)
   );

   function automatic outs_t mk(int sel, bit pw, bit rw, bit r1, bit r2, bit we, bit csr,
                                bit it, bit mr);
      outs_t o;
      o.pc_sel = 3'(sel); o.pc_write = pw; o.reg_write = rw; o.rden1 = r1; o.rden2 = r2;
      o.we2 = we; o.csr_we = csr; o.int_taken = it; o.mret = mr;
      return o;
   endfunction

   function automatic outs_t get_outs(int fw);
      if (fw == 3)
         return mk(int'(pc_sel3), pc_write3, reg_write3, rden1_3, rden2_3, we2_3, csr_we3,
                   int_taken3, mret3);
      return mk(int'(pc_sel1), pc_write1, reg_write1, rden1_1, rden2_1, we2_1, csr_we1,
                int_taken1, mret1);
   endfunction

   task automatic check(string name, outs_t act, outs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got sel=%b pw/rw/r1/r2/we/csr/it/mr=%b, expected sel=%b %b",
                  name, act.pc_sel, act[7:0], exp.pc_sel, exp[7:0]);
      end
   endtask

   // Reference model of one instruction's EXEC cycle, from the ISA meaning of the
   // instruction and the actual operand values rather than from the comparator flags.
   function automatic outs_t exec_model(logic [6:0] op, logic [2:0] f3, logic [11:0] f12,
                                        logic [31:0] a, logic [31:0] b);
      outs_t o = '0;
      bit    t = 0;
      o.pc_write = 1'b1;
      case (op)
         7'b0000011: o.rden2 = 1'b1;
         7'b0100011: o.we2 = 1'b1;
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: o.reg_write = 1'b1;
         7'b1101111: begin o.reg_write = 1'b1; o.pc_sel = 3'd3; end
         7'b1100111: begin o.reg_write = 1'b1; o.pc_sel = 3'd1; end
         7'b1100011: begin
            case (f3)
               3'd0: t = (a == b);
               3'd1: t = (a != b);
               3'd4: t = ($signed(a) <  $signed(b));
               3'd5: t = ($signed(a) >= $signed(b));
               3'd6: t = (a <  b);
               3'd7: t = (a >= b);
               default: t = 0;
            endcase
            o.pc_sel = t ? 3'd2 : 3'd0;
         end
         7'b1110011: begin
            if (f3 == 3'd0 && f12 == 12'h302) begin o.mret = 1'b1; o.pc_sel = 3'd5; end
            else if (f3 != 3'd0) begin o.csr_we = 1'b1; o.reg_write = 1'b1; end
         end
         default: ;
      endcase
      return o;
   endfunction

   function automatic cyc_t rand_cyc(outs_t exp);
      cyc_t c;
      c.op = 7'($urandom); c.f3 = 3'($urandom); c.f12 = 12'($urandom);
      c.eq = 1'($urandom); c.lt = 1'($urandom); c.ltu = 1'($urandom); c.intr = 1'($urandom);
      c.exp = exp;
      return c;
   endfunction

   // Builds the expected cycle sequence of one whole instruction, then plays it.
   task automatic run_instr(int fw, vec_t v);
      cyc_t q[$];
      cyc_t c;
      bit   trap;
      for (int k = 0; k < fw; k++) q.push_back(rand_cyc(mk(0, 0, 0, 1, 0, 0, 0, 0, 0)));
      c.op = v.op; c.f3 = v.f3; c.f12 = v.f12; c.eq = v.eq; c.lt = v.lt; c.ltu = v.ltu;
      c.intr = v.intr_exec; c.exp = v.exp_exec;
      q.push_back(c);
      if (v.op == 7'b0000011) begin
         c.intr = v.intr_wb; c.exp = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
         q.push_back(c);
         trap = v.intr_wb;
      end else begin
         trap = v.intr_exec;
      end
      if (trap) q.push_back(rand_cyc(mk(4, 1, 0, 0, 0, 0, 0, 1, 0)));
      foreach (q[i]) begin
         opcode = q[i].op; func3 = q[i].f3; func12 = q[i].f12;
         br_eq = q[i].eq; br_lt = q[i].lt; br_ltu = q[i].ltu; intr = q[i].intr;
         @(negedge clk);
         check($sformatf("%s fw%0d cyc%0d", v.name, fw, i), get_outs(fw), q[i].exp);
         @(posedge clk); #1;
      end
   endtask

   function automatic vec_t mkv(string n, logic [6:0] op, logic [2:0] f3, logic [11:0] f12,
                                bit eq, bit lt, bit ltu, bit ix, bit iw, outs_t e);
      vec_t v;
      v.name = n; v.op = op; v.f3 = f3; v.f12 = f12; v.eq = eq; v.lt = lt; v.ltu = ltu;
      v.intr_exec = ix; v.intr_wb = iw; v.exp_exec = e;
      return v;
   endfunction

   vec_t tbl[19];
   logic [6:0] op_pool[11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                               7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011,
                               7'b1111111};

   task automatic run_random(int fw, int n);
      vec_t        v;
      logic [31:0] a, b;
      for (int i = 0; i < n; i++) begin
         v.name = $sformatf("rand%0d", i);
         v.op   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 10)];
         v.f3   = 3'($urandom);
         v.f12  = ($urandom_range(0, 2) == 0) ? 12'h302 : 12'($urandom);
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         v.eq = (a == b); v.lt = ($signed(a) < $signed(b)); v.ltu = (a < b);
         v.intr_exec = ($urandom_range(0, 3) == 0);
         v.intr_wb   = ($urandom_range(0, 3) == 0);
         v.exp_exec  = exec_model(v.op, v.f3, v.f12, a, b);
         run_instr(fw, v);
      end
   endtask

   initial begin
      tbl[0]  = mkv("ADDI",      7'b0010011, 3'b000, 12'h000, 0,0,0, 0,0, mk(0,1,1,0,0,0,0,0,0));
      tbl[1]  = mkv("LW",        7'b0000011, 3'b010, 12'h000, 0,0,0, 0,0, mk(0,1,0,0,1,0,0,0,0));
      tbl[2]  = mkv("SW",        7'b0100011, 3'b010, 12'h000, 0,0,0, 0,0, mk(0,1,0,0,0,1,0,0,0));
      tbl[3]  = mkv("BLT_t",     7'b1100011, 3'b100, 12'h000, 0,1,0, 0,0, mk(2,1,0,0,0,0,0,0,0));
      tbl[4]  = mkv("BLT_nt",    7'b1100011, 3'b100, 12'h000, 0,0,1, 0,0, mk(0,1,0,0,0,0,0,0,0));
      tbl[5]  = mkv("BGEU_t",    7'b1100011, 3'b111, 12'h000, 0,1,0, 0,0, mk(2,1,0,0,0,0,0,0,0));
      tbl[6]  = mkv("BR_f3_010", 7'b1100011, 3'b010, 12'h000, 1,1,1, 0,0, mk(0,1,0,0,0,0,0,0,0));
      tbl[7]  = mkv("BEQ_t",     7'b1100011, 3'b000, 12'h000, 1,0,0, 0,0, mk(2,1,0,0,0,0,0,0,0));
      tbl[8]  = mkv("JAL",       7'b1101111, 3'b000, 12'h000, 0,0,0, 0,0, mk(3,1,1,0,0,0,0,0,0));
      tbl[9]  = mkv("JALR",      7'b1100111, 3'b000, 12'h000, 0,0,0, 0,0, mk(1,1,1,0,0,0,0,0,0));
      tbl[10] = mkv("MRET",      7'b1110011, 3'b000, 12'h302, 0,0,0, 0,0, mk(5,1,0,0,0,0,0,0,1));
      tbl[11] = mkv("CSRRW",     7'b1110011, 3'b001, 12'h300, 0,0,0, 0,0, mk(0,1,1,0,0,0,1,0,0));
      tbl[12] = mkv("ECALL",     7'b1110011, 3'b000, 12'h000, 0,0,0, 0,0, mk(0,1,0,0,0,0,0,0,0));
      tbl[13] = mkv("UNKNOWN",   7'b1111111, 3'b000, 12'h000, 1,1,1, 0,0, mk(0,1,0,0,0,0,0,0,0));
      tbl[14] = mkv("LUI",       7'b0110111, 3'b000, 12'h000, 0,0,0, 0,0, mk(0,1,1,0,0,0,0,0,0));
      tbl[15] = mkv("ADD_intr",  7'b0110011, 3'b000, 12'h000, 0,0,0, 1,0, mk(0,1,1,0,0,0,0,0,0));
      tbl[16] = mkv("LW_intr",   7'b0000011, 3'b010, 12'h000, 0,0,0, 1,1, mk(0,1,0,0,1,0,0,0,0));
      tbl[17] = mkv("LW_intr_gone", 7'b0000011, 3'b010, 12'h000, 0,0,0, 1,0, mk(0,1,0,0,1,0,0,0,0));
      tbl[18] = mkv("MRET_intr", 7'b1110011, 3'b000, 12'h302, 0,0,0, 1,0, mk(5,1,0,0,0,0,0,0,1));

      rst_n1 = 1'b0; rst_n3 = 1'b0;
      opcode = '0; func3 = '0; func12 = '0; br_eq = 0; br_lt = 0; br_ltu = 0; intr = 0;

      // Reset held for three cycles with noisy inputs: every output must stay 0.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         opcode = 7'($urandom); func3 = 3'($urandom); func12 = 12'($urandom);
         br_eq = 1'($urandom); br_lt = 1'($urandom); br_ltu = 1'($urandom); intr = 1'b1;
         @(negedge clk);
         check($sformatf("reset fw1 cyc%0d", i), get_outs(1), '0);
         check($sformatf("reset fw3 cyc%0d", i), get_outs(3), '0);
      end
      @(posedge clk); #1;
      rst_n1 = 1'b1;

      foreach (tbl[i]) run_instr(1, tbl[i]);
      run_random(1, 150);

      rst_n1 = 1'b0;
      rst_n3 = 1'b1;
      run_instr(3, tbl[0]);
      run_instr(3, tbl[16]);
      run_instr(3, tbl[15]);
      run_random(3, 40);

      // Reset dropped in the second FETCH cycle: outputs clear at once, and the
      // restarted instruction gets a full three-cycle FETCH.
      intr = 1'b0;
      @(negedge clk);
      check("midreset fetch1", get_outs(3), mk(0,0,0,1,0,0,0,0,0));
      @(posedge clk); #2;
      check("midreset fetch2", get_outs(3), mk(0,0,0,1,0,0,0,0,0));
      rst_n3 = 1'b0;
      #1;
      check("midreset immediate", get_outs(3), '0);
      @(posedge clk); #1;
      check("midreset held", get_outs(3), '0);
      rst_n3 = 1'b1;
      run_instr(3, tbl[8]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
